pipeline_stall_controller: RTL

Central hazard and sequencing controller for the five-stage pipeline. Each cycle it generates the write enables and bubble requests for the PC and for the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers. It handles four conditions:
- load-use stalls
- redirects (branch/jump) resolved in MEM
- multi-cycle RAM waits
- an external halt/drain/resume sequence

It also keeps stall and flush counters for performance measurement.

---
 rtl/pipeline_stall_controller.sv | 131 +++++++++++++
 1 files changed

// File: rtl/pipeline_stall_controller.sv
// Hazard and sequencing controller for a five-stage pipeline: generates per-stage
// write enables and bubble requests, runs the halt/drain/resume sequence, keeps perf counters.
module pipeline_stall_controller #(
    parameter int CNT_WIDTH   = 32,
    parameter int MEM_TIMEOUT = 16,
    parameter int DRAIN_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [4:0]           id_rs1_address,
    input  logic [4:0]           id_rs2_address,
    input  logic                 id_uses_rs1,
    input  logic                 id_uses_rs2,
    input  logic [4:0]           ex_rd_address,
    input  logic                 ex_is_load,
    input  logic [1:0]           mem_next_pc_src,
    input  logic                 mem_ram_req,
    input  logic                 ram_ready,
    input  logic                 halt_req,
    input  logic                 resume,
    output logic                 pc_wren,
    output logic                 if_id_wren,
    output logic                 id_ex_wren,
    output logic                 ex_mem_wren,
    output logic                 mem_wb_wren,
    output logic                 if_id_flush,
    output logic                 id_ex_flush,
    output logic                 ex_mem_flush,
    output logic                 halted,
    output logic                 mem_timeout,
    output logic [CNT_WIDTH-1:0] stall_cycles,
    output logic [CNT_WIDTH-1:0] flush_count,
    output logic [1:0]           fsm_state
);
    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        DRAIN    = 2'd2,
        HALTED   = 2'd3
    } state_t;

    state_t     state, state_next;
    logic [7:0] wait_cnt;
    logic [3:0] drain_cnt, drain_next;
    logic       memw, redir, lu, redir_taken;
    logic [4:0] wren;
    logic [2:0] flush;

    assign memw  = mem_ram_req & ~ram_ready;
    assign redir = (mem_next_pc_src != 2'd0);
    assign lu    = ex_is_load && (ex_rd_address != 5'd0) &&
                   ((id_uses_rs1 && (id_rs1_address == ex_rd_address)) ||
                    (id_uses_rs2 && (id_rs2_address == ex_rd_address)));

    // wren = {pc, if_id, id_ex, ex_mem, mem_wb}; flush = {if_id, id_ex, ex_mem}
    always_comb begin
        state_next  = state;
        drain_next  = drain_cnt;
        wren        = 5'b00000;
        flush       = 3'b000;
        redir_taken = 1'b0;
        case (state)
            RUN, MEM_WAIT, DRAIN: begin
                if (memw) begin
                    if (state == RUN) state_next = MEM_WAIT;
                end else begin
                    if (redir) begin
                        wren        = 5'b11111;
                        flush       = 3'b111;
                        redir_taken = 1'b1;
                    end else if (lu) begin
                        wren  = 5'b00111;
                        flush = 3'b010;
                    end else begin
                        wren = 5'b11111;
                    end
                    if (state == DRAIN) begin
                        // Fetch is blocked while draining; a squashed ID slot keeps IF/ID bubbling.
                        if (!redir) wren[4] = 1'b0;
                        if (redir || !lu) begin
                            wren[3]    = 1'b1;
                            flush[2]   = 1'b1;
                            drain_next = drain_cnt - 4'd1;
                            if (drain_cnt == 4'd1) state_next = HALTED;
                        end
                    end else if (state == MEM_WAIT) begin
                        state_next = RUN;
                    end else if (halt_req) begin
                        state_next = DRAIN;
                        drain_next = 4'(DRAIN_DEPTH);
                    end
                end
            end
            HALTED: begin
                if (resume) state_next = RUN;
            end
            default: state_next = RUN;
        endcase
    end

    // Enables are forced off the moment reset is asserted, independent of the clock.
    assign {pc_wren, if_id_wren, id_ex_wren, ex_mem_wren, mem_wb_wren} = reset_n ? wren : 5'b00000;
    assign {if_id_flush, id_ex_flush, ex_mem_flush} = reset_n ? flush : 3'b000;
    assign fsm_state = state;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= RUN;
            wait_cnt     <= 8'd0;
            drain_cnt    <= 4'd0;
            halted       <= 1'b0;
            mem_timeout  <= 1'b0;
            stall_cycles <= '0;
            flush_count  <= '0;
        end else begin
            state     <= state_next;
            drain_cnt <= drain_next;
            halted    <= (state_next == HALTED);
            if (memw && state != HALTED) begin
                if (wait_cnt != 8'hff) wait_cnt <= wait_cnt + 8'd1;
                if (wait_cnt == 8'(MEM_TIMEOUT - 1)) mem_timeout <= 1'b1;
            end else begin
                wait_cnt <= 8'd0;
            end
            if (state != HALTED && (memw || lu) && stall_cycles != '1)
                stall_cycles <= stall_cycles + 1'b1;
            if (redir_taken && flush_count != '1)
                flush_count <= flush_count + 1'b1;
        end
    end
endmodule
